// File: rtl/sha256_round_ctrl_pkg.sv
// Shared constants, state encodings and output payload for the SHA-256 round sequencer.
package sha256_round_ctrl_pkg;

    localparam int unsigned ROUNDS      = 64;
    localparam int unsigned MSG_WORDS   = 16;
    localparam int unsigned ROM_LATENCY = 1;
    localparam int unsigned RIDX_W      = $clog2(ROUNDS);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRIME = 3'd1;
    localparam logic [2:0] ST_ROUND = 3'd2;
    localparam logic [2:0] ST_FINAL = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef struct packed {
        logic [RIDX_W-1:0] k_addr;
        logic              k_ena;
        logic              init_load;
        logic              round_valid;
        logic [RIDX_W-1:0] round_idx;
        logic              w_sel_msg;
        logic              final_add;
        logic              busy;
        logic              done;
    } seq_out_t;

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Handshake and strobe bundle between block controller, round sequencer and K ROM / datapath.
interface sha256_round_ctrl_if;
    import sha256_round_ctrl_pkg::*;

    logic              start;
    logic              stall;
    logic              abort;
    logic [RIDX_W-1:0] k_addr;
    logic              k_ena;
    logic              init_load;
    logic              round_valid;
    logic [RIDX_W-1:0] round_idx;
    logic              w_sel_msg;
    logic              final_add;
    logic              busy;
    logic              done;

    modport master (
        output start, stall, abort,
        input  k_addr, k_ena, init_load, round_valid, round_idx,
               w_sel_msg, final_add, busy, done
    );

    modport slave (
        input  start, stall, abort,
        output k_addr, k_ena, init_load, round_valid, round_idx,
               w_sel_msg, final_add, busy, done
    );

endinterface

// File: rtl/sha256_round_ctrl.sv
// Sequences one SHA-256 compression pass: primes the K ROM, issues 64 rounds, then final-add.
// All outputs are registered from the next state, so start/stall/abort act one cycle later.
module sha256_round_ctrl
    import sha256_round_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    sha256_round_ctrl_if.slave      bus
);

    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(ROUNDS - 1);
    localparam logic [RIDX_W-1:0] MSG_LIMIT  = RIDX_W'(MSG_WORDS);
    localparam logic [RIDX_W-1:0] PREFETCH   = RIDX_W'(ROM_LATENCY);

    logic [2:0]        state_q, state_d;
    logic [RIDX_W-1:0] r_q, r_d;
    seq_out_t          out_q, out_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            out_q   <= out_d;
        end
    end

    // Round advances only after a cycle that actually issued a round, keeping r aligned with the ROM.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        out_d   = '0;

        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_PRIME;
            ST_PRIME: begin
                state_d = ST_ROUND;
                r_d     = '0;
            end
            ST_ROUND: begin
                if (out_q.round_valid) begin
                    if (r_q == LAST_ROUND) state_d = ST_FINAL;
                    else                   r_d = RIDX_W'(r_q + 1'b1);
                end
            end
            ST_FINAL: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (bus.abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
        if (state_d != ST_ROUND) r_d = '0;

        case (state_d)
            ST_PRIME: begin
                out_d.k_ena     = 1'b1;
                out_d.init_load = 1'b1;
                out_d.busy      = 1'b1;
            end
            ST_ROUND: begin
                out_d.busy        = 1'b1;
                out_d.round_idx   = r_d;
                out_d.round_valid = !bus.stall;
                out_d.w_sel_msg   = !bus.stall && (r_d < MSG_LIMIT);
                // During a stall the ROM enable drops so it keeps presenting K[r].
                out_d.k_ena       = !bus.stall && (r_d != LAST_ROUND);
                out_d.k_addr      = out_d.k_ena ? RIDX_W'(r_d + PREFETCH) : r_d;
            end
            ST_FINAL: begin
                out_d.final_add = 1'b1;
                out_d.busy      = 1'b1;
            end
            ST_DONE:  out_d.done = 1'b1;
            default:  out_d = '0;
        endcase
    end

    assign bus.k_addr      = out_q.k_addr;
    assign bus.k_ena       = out_q.k_ena;
    assign bus.init_load   = out_q.init_load;
    assign bus.round_valid = out_q.round_valid;
    assign bus.round_idx   = out_q.round_idx;
    assign bus.w_sel_msg   = out_q.w_sel_msg;
    assign bus.final_add   = out_q.final_add;
    assign bus.busy        = out_q.busy;
    assign bus.done        = out_q.done;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl with a registered K ROM model beside the sequencer.
module tb_sha256_round_ctrl;
    import sha256_round_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    sha256_round_ctrl_if bus ();

    sha256_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // K ROM: one-cycle registered read, holds output while disabled.
    logic [31:0] rom_q = 32'h0;
    always @(posedge clk) if (bus.k_ena) rom_q <= k_tab[bus.k_addr];

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_idx, valid_cnt, wsel_cnt, final_cnt, done_cnt;
    int first_v, last_v, final_cyc, done_cyc;
    int init_at [$];
    logic [31:0] k_first, k_last, k_11;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.k_addr, bus.k_ena, bus.init_load, bus.round_valid, bus.round_idx,
                    bus.w_sel_msg, bus.final_add, bus.busy, bus.done});
    endfunction

    // Pass monitor: round order, ROM contents and strobe timing relative to t0.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.init_load) begin
                init_at.push_back(cyc - t0);
                exp_idx = 0;
            end
            if (bus.w_sel_msg) wsel_cnt++;
            if (bus.round_valid) begin
                chk("round_idx", 32'(bus.round_idx), 32'(exp_idx));
                chk("k_value", rom_q, k_tab[exp_idx[5:0]]);
                chk("w_sel_msg", 32'(bus.w_sel_msg), 32'(exp_idx < 16));
                if (exp_idx == 0)  begin first_v = cyc - t0; k_first = rom_q; end
                if (exp_idx == 11) k_11 = rom_q;
                if (exp_idx == 63) k_last = rom_q;
                last_v = cyc - t0;
                exp_idx++;
                valid_cnt++;
            end
            if (bus.final_add) begin final_cnt++; final_cyc = cyc - t0; end
            if (bus.done)      begin done_cnt++;  done_cyc  = cyc - t0; end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        exp_idx = 0; valid_cnt = 0; wsel_cnt = 0; final_cnt = 0; done_cnt = 0;
        first_v = -1; last_v = -1; final_cyc = -1; done_cyc = -1;
        k_first = '0; k_last = '0; k_11 = '0;
        init_at.delete();
    endtask

    task automatic start_pass();
        clear();
        t0 = cyc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin tick(); n++; end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic wait_round(input int idx, input int budget);
        int n = 0;
        while (!(bus.round_valid && int'(bus.round_idx) == idx) && n < budget) begin tick(); n++; end
        chk("round_reached", 32'(bus.round_valid && int'(bus.round_idx) == idx), 32'd1);
    endtask

    function automatic int init_n(input int i);
        return (init_at.size() > i) ? init_at[i] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        bus.start = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0;
        clear();
        repeat (3) tick();
        chk("reset_outs", outs(), 32'h0);
        rst = 1'b1;
        repeat (2) tick();
        chk("idle_outs", outs(), 32'h0);

        // Nominal unstalled pass
        start_pass();
        wait_done(100);
        repeat (3) tick();
        chk("nom_init_cyc", 32'(init_n(0)), 32'd1);
        chk("nom_n_init", 32'(init_at.size()), 32'd1);
        chk("nom_first_valid", 32'(first_v), 32'd2);
        chk("nom_last_valid", 32'(last_v), 32'd65);
        chk("nom_valid_cnt", 32'(valid_cnt), 32'd64);
        chk("nom_wsel_cnt", 32'(wsel_cnt), 32'd16);
        chk("nom_k0", k_first, 32'h428a2f98);
        chk("nom_k63", k_last, 32'hc67178f2);
        chk("nom_final_cyc", 32'(final_cyc), 32'd66);
        chk("nom_final_cnt", 32'(final_cnt), 32'd1);
        chk("nom_done_cyc", 32'(done_cyc), 32'd67);
        chk("nom_done_cnt", 32'(done_cnt), 32'd1);
        chk("nom_idle_outs", outs(), 32'h0);

        // Three stall cycles parked on round 10
        start_pass();
        wait_round(9, 40);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(bus.round_valid), 32'd0);
            chk("stall_idx", 32'(bus.round_idx), 32'd10);
            chk("stall_k_ena", 32'(bus.k_ena), 32'd0);
            chk("stall_rom", rom_q, 32'h243185be);
            chk("stall_busy", 32'(bus.busy), 32'd1);
        end
        bus.stall = 1'b0;
        wait_done(100);
        repeat (3) tick();
        chk("stall_k11", k_11, 32'h550c7dc3);
        chk("stall_valid_cnt", 32'(valid_cnt), 32'd64);
        chk("stall_done_cyc", 32'(done_cyc), 32'd70);

        // Start pulse while busy is ignored
        start_pass();
        wait_round(20, 40);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(100);
        repeat (10) tick();
        chk("busy_start_done_cyc", 32'(done_cyc), 32'd67);
        chk("busy_start_done_cnt", 32'(done_cnt), 32'd1);
        chk("busy_start_n_init", 32'(init_at.size()), 32'd1);

        // Abort mid-pass, then a fresh full pass
        start_pass();
        wait_round(30, 50);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_outs", outs(), 32'h0);
        repeat (80) tick();
        chk("abort_final_cnt", 32'(final_cnt), 32'd0);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_valid_cnt", 32'(valid_cnt), 32'd31);
        start_pass();
        wait_done(100);
        tick();
        chk("post_abort_valid_cnt", 32'(valid_cnt), 32'd64);
        chk("post_abort_done_cyc", 32'(done_cyc), 32'd67);

        // Asynchronous reset mid-pass
        start_pass();
        wait_round(40, 60);
        rst = 1'b0;
        #1;
        chk("mid_reset_outs", outs(), 32'h0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("mid_reset_done_cnt", 32'(done_cnt), 32'd0);
        chk("mid_reset_final_cnt", 32'(final_cnt), 32'd0);
        start_pass();
        wait_done(100);
        tick();
        chk("post_reset_first_valid", 32'(first_v), 32'd2);
        chk("post_reset_valid_cnt", 32'(valid_cnt), 32'd64);
        chk("post_reset_done_cyc", 32'(done_cyc), 32'd67);

        // Start held high: a new pass every 68 cycles
        clear();
        t0 = cyc;
        bus.start = 1'b1;
        repeat (140) tick();
        bus.start = 1'b0;
        chk("b2b_n_init", 32'(init_at.size()), 32'd3);
        chk("b2b_init0", 32'(init_n(0)), 32'd1);
        chk("b2b_init1", 32'(init_n(1)), 32'd69);
        chk("b2b_init2", 32'(init_n(2)), 32'd137);
        chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
        chk("b2b_done_cyc", 32'(done_cyc), 32'd135);
        repeat (80) tick();
        chk("b2b_final_done_cnt", 32'(done_cnt), 32'd3);
        chk("b2b_idle_outs", outs(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
